// File: rtl/imem_loadable_fetch.sv
// Loadable instruction memory: boot-time streaming load port, then a
// request/response fetch port with a 1-entry registered output slot.
module imem_loadable_fetch #(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       ADDR_W   = 10,
  parameter int unsigned       DEPTH    = 1024,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              loaded,
  output logic [ADDR_W:0]   load_count,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  input  logic              inst_ready,
  output logic              addr_err
);

  localparam int unsigned     IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic {S_LOAD, S_RUN} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                inst_valid_q;
  logic [DATA_W-1:0]   inst_q;
  logic                addr_err_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                load_fire, load_done, fetch_fire, in_range;

  assign load_fire  = load_valid && load_ready;
  // Stop on load_last or on the final implemented word, so the memory cannot overfill.
  assign load_done  = load_fire && (load_last || (count_q == LAST_PTR));
  assign fetch_fire = fetch_valid && fetch_ready;
  assign in_range   = {1'b0, fetch_addr} < DEPTH_C;

  // FSM: state register
  always_ff @(posedge Clk) begin
    if (Rst) state_q <= S_LOAD;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:  if (load_done) state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_LOAD;
    endcase
  end

  // FSM: outputs
  always_comb begin
    load_ready  = 1'b0;
    loaded      = 1'b0;
    fetch_ready = 1'b0;
    case (state_q)
      S_LOAD:  load_ready  = 1'b1;
      S_RUN: begin
        loaded      = 1'b1;
        fetch_ready = !inst_valid_q || inst_ready;
      end
      default: ;
    endcase
  end

  // Load counter doubles as the write pointer.
  always_comb begin
    count_d = count_q;
    if (load_fire) count_d = count_q + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Rst) count_q <= '0;
    else     count_q <= count_d;
  end

  // Storage is deliberately not reset.
  always_ff @(posedge Clk) begin
    if (!Rst && load_fire) mem[count_q[IDX_W-1:0]] <= load_data;
  end

  // Registered read straight into the output slot; slot holds while stalled.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      addr_err_q   <= 1'b0;
    end else if (fetch_fire) begin
      inst_valid_q <= 1'b1;
      addr_err_q   <= !in_range;
      if (in_range) inst_q <= mem[fetch_addr[IDX_W-1:0]];
      else          inst_q <= NOP_WORD;
    end else if (inst_ready) begin
      inst_valid_q <= 1'b0;
    end
  end

  assign load_count = count_q;
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_imem_loadable_fetch.sv
// Directed bench for imem_loadable_fetch (DEPTH=8, ADDR_W=4, NOP_WORD=0xF000).
module tb_imem_loadable_fetch;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 4;

  logic              Clk = 1'b0;
  logic              Rst;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              loaded;
  logic [ADDR_W:0]   load_count;
  logic              fetch_valid;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready;
  logic              inst_valid;
  logic [DATA_W-1:0] inst;
  logic              inst_ready;
  logic              addr_err;

  int tests = 0;
  int fails = 0;

  imem_loadable_fetch #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (8),
    .NOP_WORD (16'hF000)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .loaded      (loaded),
    .load_count  (load_count),
    .fetch_valid (fetch_valid),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_ready  (inst_ready),
    .addr_err    (addr_err)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic load_word(input logic [DATA_W-1:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  initial begin
    Rst = 1'b1; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    fetch_valid = 1'b0; fetch_addr = '0; inst_ready = 1'b1;
    tick(); tick();
    Rst = 1'b0;
    #1;
    chk("rst_loaded", loaded, 0);
    chk("rst_count", load_count, 0);
    chk("rst_ivalid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_err", addr_err, 0);
    chk("rst_lready", load_ready, 1);
    fetch_valid = 1'b1;
    #1;
    chk("load_fready", fetch_ready, 0);

    // Test 1: 4 words with an idle gap; fetch held high must be ignored in LOAD
    load_word(16'h1111, 1'b0);
    load_word(16'h2222, 1'b0);
    tick();
    chk("idle_count", load_count, 2);
    chk("load_no_fetch", inst_valid, 0);
    load_word(16'h3333, 1'b0);
    chk("t1_pre_loaded", loaded, 0);
    chk("t1_pre_count", load_count, 3);
    fetch_valid = 1'b0;
    load_word(16'h4444, 1'b1);
    chk("t1_loaded", loaded, 1);
    chk("t1_count", load_count, 4);
    chk("t1_lready", load_ready, 0);

    // Test 2: single fetch then back-to-back
    fetch_valid = 1'b1; fetch_addr = 4'd2; inst_ready = 1'b1;
    #1;
    chk("t2_fready", fetch_ready, 1);
    tick();
    chk("t2_v2", inst_valid, 1);
    chk("t2_d2", inst, 16'h3333);
    chk("t2_e2", addr_err, 0);
    fetch_addr = 4'd0; tick();
    chk("t2_d0", inst, 16'h1111);
    chk("t2_v0", inst_valid, 1);
    fetch_addr = 4'd1; tick();
    chk("t2_d1", inst, 16'h2222);
    fetch_addr = 4'd3; tick();
    chk("t2_d3", inst, 16'h4444);
    fetch_valid = 1'b0; tick();
    chk("drain_valid", inst_valid, 0);
    chk("drain_hold", inst, 16'h4444);

    // Test 4: out-of-range then in-range
    fetch_valid = 1'b1; fetch_addr = 4'd8; tick();
    chk("oor_inst", inst, 16'hF000);
    chk("oor_err", addr_err, 1);
    chk("oor_valid", inst_valid, 1);
    fetch_addr = 4'd15; tick();
    chk("oor15_err", addr_err, 1);
    fetch_addr = 4'd1; tick();
    chk("inr_inst", inst, 16'h2222);
    chk("inr_err", addr_err, 0);

    // Test 5: stall 3 cycles with pending fetch of addr 3, then release
    inst_ready = 1'b0; fetch_addr = 4'd3;
    #1;
    chk("stall_fready0", fetch_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_inst", inst, 16'h2222);
      chk("stall_valid", inst_valid, 1);
      chk("stall_err", addr_err, 0);
      chk("stall_fready", fetch_ready, 0);
    end
    inst_ready = 1'b1;
    #1;
    chk("release_fready", fetch_ready, 1);
    tick();
    chk("release_inst", inst, 16'h4444);
    chk("release_valid", inst_valid, 1);

    // Test 3: reset with response pending, then fill DEPTH=8 without load_last
    fetch_valid = 1'b0;
    Rst = 1'b1; tick(); Rst = 1'b0;
    chk("t3_rst_valid", inst_valid, 0);
    chk("t3_rst_loaded", loaded, 0);
    for (int i = 0; i < 8; i++) begin
      load_word(16'hA000 + 16'(i), 1'b0);
      if (i == 6) chk("t3_pre_loaded", loaded, 0);
    end
    chk("t3_loaded", loaded, 1);
    chk("t3_count", load_count, 8);
    load_word(16'hBEEF, 1'b0);
    chk("t3_no_overfill", load_count, 8);
    fetch_valid = 1'b1; fetch_addr = 4'd0; tick();
    chk("t3_mem0", inst, 16'hA000);
    fetch_addr = 4'd7; tick();
    chk("t3_mem7", inst, 16'hA007);
    chk("t3_err7", addr_err, 0);
    fetch_valid = 1'b0; tick();

    // Test 6: reset mid-load, Rst priority over load_valid, reload one word
    Rst = 1'b1; tick(); Rst = 1'b0;
    load_word(16'h5555, 1'b0);
    load_word(16'h6666, 1'b0);
    chk("t6_mid_count", load_count, 2);
    Rst = 1'b1; load_valid = 1'b1; load_data = 16'h9999; tick();
    Rst = 1'b0; load_valid = 1'b0;
    chk("t6_loaded", loaded, 0);
    chk("t6_count", load_count, 0);
    chk("t6_valid", inst_valid, 0);
    load_word(16'h7777, 1'b1);
    chk("t6_reloaded", loaded, 1);
    chk("t6_recount", load_count, 1);
    fetch_valid = 1'b1; fetch_addr = 4'd0; tick();
    chk("t6_inst", inst, 16'h7777);
    fetch_addr = 4'd1; tick();
    chk("t6_old_word", inst, 16'h6666);
    fetch_valid = 1'b0; tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
